// File: rtl/counter_run_ctrl_pkg.sv
// Shared widths and FSM state encoding for the counter run/stop sequencer.
package counter_run_ctrl_pkg;

    localparam int unsigned DefCntW      = 4;
    localparam int unsigned DefPrescaleW = 3;
    localparam int unsigned DefWrapW     = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/run_tick_gen.sv
// RUN-time tick source: a free prescaler when COUNTER_RUN_CTRL_PRESCALE_EN is defined,
// otherwise a tick on every RUN cycle.
module run_tick_gen #(
    parameter int unsigned PrescaleW = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    input  logic restart_i,
    output logic tick_o
);

`ifdef COUNTER_RUN_CTRL_PRESCALE_EN
    logic [PrescaleW-1:0] pre_q, pre_d;

    always_comb begin
        pre_d = pre_q;
        if (restart_i) begin
            pre_d = '0;
        end else if (run_i) begin
            pre_d = pre_q + PrescaleW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // Tick on the last cycle of each 2**PrescaleW window spent in RUN.
    assign tick_o = run_i && (pre_q == {PrescaleW{1'b1}});
`else
    logic unused_inputs;
    assign unused_inputs = ^{clk_i, rst_ni, restart_i, PrescaleW[0]};
    assign tick_o        = run_i;
`endif

endmodule

// File: rtl/counter_run_ctrl.sv
// Run/stop sequencer driving an external enable counter; optional prescaled tick via
// COUNTER_RUN_CTRL_PRESCALE_EN (see run_tick_gen).
module counter_run_ctrl
    import counter_run_ctrl_pkg::*;
#(
    parameter int unsigned CntW      = DefCntW,
    parameter int unsigned PrescaleW = DefPrescaleW,
    parameter int unsigned WrapW     = DefWrapW
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            stop_i,
    input  logic            reload_i,
    input  logic [CntW-1:0] limit_i,
    input  logic [CntW-1:0] cnt_val_i,
    output logic            cnt_en_o,
    output logic            cnt_clr_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [WrapW-1:0] wrap_cnt_o
);

    state_e           state_q, state_d;
    logic [CntW-1:0]  limit_q, limit_d;
    logic             reload_q, reload_d;
    logic [WrapW-1:0] wrap_q, wrap_d;
    logic             cnt_en_q, cnt_en_d;
    logic             cnt_clr_q, cnt_clr_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             tick;
    logic [CntW-1:0]  eff_val;

    run_tick_gen #(
        .PrescaleW (PrescaleW)
    ) u_tick (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .run_i     (state_q == StRun),
        .restart_i (state_q != StRun),
        .tick_o    (tick)
    );

    // Outputs are registered, so cnt_val lags our own enable/clear by a cycle; judge the
    // terminal condition on the value the counter holds once this cycle's update lands.
    assign eff_val = cnt_clr_q ? '0 : cnt_val_i + CntW'(cnt_en_q);

    always_comb begin
        state_d   = state_q;
        limit_d   = limit_q;
        reload_d  = reload_q;
        wrap_d    = wrap_q;
        cnt_en_d  = 1'b0;
        cnt_clr_d = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i && !stop_i) begin
                    limit_d   = limit_i;
                    reload_d  = reload_i;
                    wrap_d    = '0;
                    cnt_clr_d = 1'b1;
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (stop_i) begin
                    state_d = StPause;
                end else if (tick) begin
                    if (eff_val == limit_q) begin
                        done_d = 1'b1;
                        if (reload_q) begin
                            cnt_clr_d = 1'b1;
                            wrap_d    = wrap_q + WrapW'(1);
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        cnt_en_d = 1'b1;
                    end
                end
            end
            StPause: begin
                if (stop_i) begin
                    cnt_clr_d = 1'b1;
                    state_d   = StIdle;
                end else if (start_i) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StRun) || (state_d == StPause);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            limit_q   <= '0;
            reload_q  <= 1'b0;
            wrap_q    <= '0;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            limit_q   <= limit_d;
            reload_q  <= reload_d;
            wrap_q    <= wrap_d;
            cnt_en_q  <= cnt_en_d;
            cnt_clr_q <= cnt_clr_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign cnt_en_o   = cnt_en_q;
    assign cnt_clr_o  = cnt_clr_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign wrap_cnt_o = wrap_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed bench for counter_run_ctrl paired with a 4-bit counter model; the prescaled
// scenario runs only when COUNTER_RUN_CTRL_PRESCALE_EN is defined.
module tb_counter_run_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, reload;
    logic [3:0] limit;
    logic [3:0] cnt_val;
    logic       cnt_en, cnt_clr, busy, done;
    logic [3:0] wrap_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    counter_run_ctrl dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .stop_i     (stop),
        .reload_i   (reload),
        .limit_i    (limit),
        .cnt_val_i  (cnt_val),
        .cnt_en_o   (cnt_en),
        .cnt_clr_o  (cnt_clr),
        .busy_o     (busy),
        .done_o     (done),
        .wrap_cnt_o (wrap_cnt)
    );

    // Counter datapath model: clear beats enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_val <= 4'd0;
        end else if (cnt_clr) begin
            cnt_val <= 4'd0;
        end else if (cnt_en) begin
            cnt_val <= cnt_val + 4'd1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Pulse start for one cycle; returns in the first cycle after the start edge.
    task automatic start_run(input logic [3:0] lim, input logic rl);
        limit  = lim;
        reload = rl;
        start  = 1'b1;
        cyc();
        start  = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        reload = 1'b0;
        limit  = 4'd0;
        #2 rst_n = 1'b0;
        cyc();
        chk("rst en", int'(cnt_en), 0);
        chk("rst clr", int'(cnt_clr), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst wrap", int'(wrap_cnt), 0);
        rst_n = 1'b1;
        cyc();

`ifdef COUNTER_RUN_CTRL_PRESCALE_EN
        // Prescaled: ticks at RUN cycles 8, 16, 24 -> enables at +9, +17, done at +25.
        start_run(4'd2, 1'b0);
        chk("ps clr", int'(cnt_clr), 1);
        for (int c = 2; c <= 26; c++) begin
            cyc();
            chk("ps en", int'(cnt_en), int'(c == 9 || c == 17));
            chk("ps done", int'(done), int'(c == 25));
        end
        chk("ps cnt", int'(cnt_val), 2);
        chk("ps busy", int'(busy), 0);
`else
        // One-shot to 5.
        start_run(4'd5, 1'b0);
        chk("os clr", int'(cnt_clr), 1);
        chk("os en0", int'(cnt_en), 0);
        chk("os busy", int'(busy), 1);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("os cnt", int'(cnt_val), k);
            chk("os en", int'(cnt_en), 1);
            chk("os done0", int'(done), 0);
        end
        cyc();
        chk("os cnt5", int'(cnt_val), 5);
        chk("os done", int'(done), 1);
        chk("os en_term", int'(cnt_en), 0);
        chk("os busy_done", int'(busy), 0);
        cyc();
        chk("os done_pulse", int'(done), 0);
        chk("os hold", int'(cnt_val), 5);

        // Auto-reload at 3, restarting from DONE.
        start_run(4'd3, 1'b1);
        chk("ar clr", int'(cnt_clr), 1);
        for (int k = 0; k < 18; k++) begin
            cyc();
            chk("ar cnt", int'(cnt_val), k % 4);
            chk("ar done", int'(done), int'(k % 4 == 3));
            chk("ar clr", int'(cnt_clr), int'(k % 4 == 3));
            chk("ar en", int'(cnt_en), int'(k % 4 != 3));
            chk("ar wrap", int'(wrap_cnt), (k + 1) / 4);
        end
        chk("ar wrap4", int'(wrap_cnt), 4);
        stop = 1'b1;
        cyc();
        chk("ar pause busy", int'(busy), 1);
        chk("ar pause en", int'(cnt_en), 0);
        chk("ar pause cnt", int'(cnt_val), 2);
        cyc();
        chk("ar idle busy", int'(busy), 0);
        chk("ar idle clr", int'(cnt_clr), 1);
        stop = 1'b0;
        cyc();
        chk("ar idle cnt", int'(cnt_val), 0);
        chk("ar idle clr0", int'(cnt_clr), 0);

        // Pause at 2, resume without clear, then stop twice to IDLE.
        start_run(4'd9, 1'b0);
        cyc();
        cyc();
        chk("pz cnt1", int'(cnt_val), 1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("pz busy", int'(busy), 1);
        chk("pz en", int'(cnt_en), 0);
        chk("pz cnt", int'(cnt_val), 2);
        cyc();
        chk("pz hold", int'(cnt_val), 2);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("rs clr", int'(cnt_clr), 0);
        chk("rs en0", int'(cnt_en), 0);
        chk("rs cnt", int'(cnt_val), 2);
        cyc();
        chk("rs en", int'(cnt_en), 1);
        chk("rs clr2", int'(cnt_clr), 0);
        cyc();
        chk("rs cnt3", int'(cnt_val), 3);
        stop = 1'b1;
        cyc();
        chk("ss pause cnt", int'(cnt_val), 4);
        cyc();
        chk("ss clr", int'(cnt_clr), 1);
        chk("ss busy", int'(busy), 0);
        stop = 1'b0;
        cyc();
        chk("ss cnt0", int'(cnt_val), 0);

        // start and stop together in IDLE: nothing happens.
        limit = 4'd7;
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_same busy", int'(busy), 0);
        chk("ss_same clr", int'(cnt_clr), 0);
        cyc();
        chk("ss_same busy2", int'(busy), 0);

        // limit=0 one-shot: done on first tick, count never moves.
        start_run(4'd0, 1'b0);
        chk("l0 clr", int'(cnt_clr), 1);
        cyc();
        chk("l0 done", int'(done), 1);
        chk("l0 en", int'(cnt_en), 0);
        chk("l0 busy", int'(busy), 0);
        chk("l0 cnt", int'(cnt_val), 0);
        cyc();
        chk("l0 done_pulse", int'(done), 0);
        chk("l0 cnt_hold", int'(cnt_val), 0);

        // Asynchronous reset mid-run at count 4.
        start_run(4'd9, 1'b0);
        repeat (5) cyc();
        chk("ar4 cnt", int'(cnt_val), 4);
        rst_n = 1'b0;
        #1;
        chk("mr en", int'(cnt_en), 0);
        chk("mr clr", int'(cnt_clr), 0);
        chk("mr busy", int'(busy), 0);
        chk("mr done", int'(done), 0);
        chk("mr wrap", int'(wrap_cnt), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("mr idle", int'(busy), 0);
        start_run(4'd1, 1'b0);
        chk("mr2 clr", int'(cnt_clr), 1);
        cyc();
        chk("mr2 en", int'(cnt_en), 1);
        cyc();
        chk("mr2 done", int'(done), 1);
        chk("mr2 cnt", int'(cnt_val), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
